// File: rtl/beat_detector_if.sv
// Flux-sample input and beat-report outputs of beat_detector, grouped as one bus.
// A sample is transferred on every clock where flux_valid is high; there is no backpressure.
interface beat_detector_if #(
    parameter int MAX_FLUX_LENGTH = 32,
    parameter int INT_W           = 16
) ();
    logic                       flux_valid;
    logic [MAX_FLUX_LENGTH-1:0] flux_value;
    logic                       beat_pulse;
    logic [MAX_FLUX_LENGTH-1:0] beat_strength;
    logic [MAX_FLUX_LENGTH-1:0] threshold;
    logic [MAX_FLUX_LENGTH-1:0] flux_avg;
    logic [INT_W-1:0]           beat_interval;
    logic                       interval_valid;
    logic                       hist_full;

    modport master (
        output flux_valid, flux_value,
        input  beat_pulse, beat_strength, threshold, flux_avg,
        input  beat_interval, interval_valid, hist_full
    );

    modport slave (
        input  flux_valid, flux_value,
        output beat_pulse, beat_strength, threshold, flux_avg,
        output beat_interval, interval_valid, hist_full
    );
endinterface

// File: rtl/beat_detector.sv
// Adaptive-threshold beat detector: compares each flux sample against a scaled moving
// average of the previous 2^HIST_LOG2 samples, with refractory hold-off and beat interval.
module beat_detector #(
    parameter int MAX_FLUX_LENGTH = 32,
    parameter int HIST_LOG2       = 3,
    parameter int K_NUM           = 3,
    parameter int K_SHIFT         = 1,
    parameter int REFRACTORY      = 4,
    parameter int MIN_FLUX        = 16,
    parameter int INT_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    beat_detector_if.slave bus
);
    localparam int W      = MAX_FLUX_LENGTH;
    localparam int HIST   = 1 << HIST_LOG2;
    localparam int SUM_W  = W + HIST_LOG2;
    localparam int FILL_W = HIST_LOG2 + 1;
    localparam int PROD_W = W + $clog2(K_NUM + 1);
    localparam int REFR_W = $clog2(REFRACTORY + 1);

    logic [W-1:0]         r_hist [HIST];
    logic [SUM_W-1:0]     r_sum;
    logic [HIST_LOG2-1:0] r_wr_ptr;
    logic [FILL_W-1:0]    r_fill;
    logic [REFR_W-1:0]    r_refr_cnt;
    logic [INT_W-1:0]     r_int_cnt;
    logic                 r_seen_beat;

    logic                 r_beat_pulse;
    logic [W-1:0]         r_beat_strength;
    logic [W-1:0]         r_threshold;
    logic [W-1:0]         r_flux_avg;
    logic [INT_W-1:0]     r_beat_interval;
    logic                 r_interval_valid;

    logic [W-1:0]         w_avg;
    logic [PROD_W-1:0]    w_prod;
    logic [PROD_W-1:0]    w_shift;
    logic [W-1:0]         w_thr;
    logic                 w_hist_full;
    logic                 w_beat;
    logic [INT_W-1:0]     w_int_next;

    // Decision uses the history as it stands before this sample is written.
    assign w_avg       = W'(r_sum >> HIST_LOG2);
    assign w_prod      = PROD_W'(w_avg) * PROD_W'(K_NUM);
    assign w_shift     = w_prod >> K_SHIFT;
    assign w_thr       = (|w_shift[PROD_W-1:W]) ? '1 : w_shift[W-1:0];
    assign w_hist_full = (r_fill == FILL_W'(HIST));
    assign w_beat      = w_hist_full
                      && (bus.flux_value > w_thr)
                      && (bus.flux_value >= W'(MIN_FLUX))
                      && (r_refr_cnt == '0);
    assign w_int_next  = (r_int_cnt == '1) ? r_int_cnt : r_int_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < HIST; i++) r_hist[i] <= '0;
            r_sum            <= '0;
            r_wr_ptr         <= '0;
            r_fill           <= '0;
            r_refr_cnt       <= '0;
            r_int_cnt        <= '0;
            r_seen_beat      <= 1'b0;
            r_beat_pulse     <= 1'b0;
            r_beat_strength  <= '0;
            r_threshold      <= '0;
            r_flux_avg       <= '0;
            r_beat_interval  <= '0;
            r_interval_valid <= 1'b0;
        end else begin
            r_beat_pulse     <= 1'b0;
            r_interval_valid <= 1'b0;
            if (bus.flux_valid) begin
                r_flux_avg       <= w_avg;
                r_threshold      <= w_thr;
                r_sum            <= r_sum - SUM_W'(r_hist[r_wr_ptr]) + SUM_W'(bus.flux_value);
                r_hist[r_wr_ptr] <= bus.flux_value;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
                if (!w_hist_full) r_fill <= r_fill + 1'b1;
                if (r_refr_cnt != '0) r_refr_cnt <= r_refr_cnt - 1'b1;
                if (r_seen_beat) r_int_cnt <= w_int_next;
                // A beat restarts the interval count; the first beat only arms it.
                if (w_beat) begin
                    r_beat_pulse    <= 1'b1;
                    r_beat_strength <= bus.flux_value - w_thr;
                    r_refr_cnt      <= REFR_W'(REFRACTORY);
                    r_seen_beat     <= 1'b1;
                    r_int_cnt       <= '0;
                    if (r_seen_beat) begin
                        r_beat_interval  <= w_int_next;
                        r_interval_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.beat_pulse     = r_beat_pulse;
    assign bus.beat_strength  = r_beat_strength;
    assign bus.threshold      = r_threshold;
    assign bus.flux_avg       = r_flux_avg;
    assign bus.beat_interval  = r_beat_interval;
    assign bus.interval_valid = r_interval_valid;
    assign bus.hist_full      = w_hist_full;
endmodule

// File: tb/tb_beat_detector.sv
// Bench for beat_detector: directed scenarios plus random flux, scored against a
// queue-based reference model; a monitor compares every output cycle.
module tb_beat_detector;
    localparam int  W          = 32;
    localparam int  IW         = 16;
    localparam int  HIST       = 8;
    localparam int  K_NUM      = 3;
    localparam int  K_SHIFT    = 1;
    localparam int  REFRACTORY = 4;
    localparam int  MIN_FLUX   = 16;
    localparam longint MAXV    = 64'hFFFF_FFFF;
    localparam longint MAXI    = 64'hFFFF;

    typedef struct packed {
        logic          beat;
        logic [W-1:0]  strength;
        logic [W-1:0]  thr;
        logic [W-1:0]  avg;
        logic [IW-1:0] interval;
        logic          ival;
        logic          full;
    } exp_t;

    logic clk;
    logic reset;
    beat_detector_if #(.MAX_FLUX_LENGTH(W), .INT_W(IW)) bus ();

    beat_detector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // reference model: whole-sample view of the rules
    longint m_hist[$];
    longint m_idx;
    longint m_last_beat;
    bit     m_seen;
    longint m_strength;
    longint m_interval;

    task automatic model_reset();
        m_hist.delete();
        m_idx       = 0;
        m_last_beat = 0;
        m_seen      = 0;
        m_strength  = 0;
        m_interval  = 0;
    endtask

    task automatic model_sample(input longint v);
        longint sum, avg, thr;
        bit     allowed, beat, ival;
        exp_t   e;
        sum = 0;
        foreach (m_hist[i]) sum += m_hist[i];
        avg = sum / HIST;
        thr = (avg * K_NUM) >> K_SHIFT;
        if (thr > MAXV) thr = MAXV;
        m_idx++;
        allowed = !m_seen || (m_idx - m_last_beat > REFRACTORY);
        beat = (m_hist.size() == HIST) && (v > thr) && (v >= MIN_FLUX) && allowed;
        ival = 0;
        if (beat) begin
            m_strength = v - thr;
            if (m_seen) begin
                m_interval = (m_idx - m_last_beat > MAXI) ? MAXI : m_idx - m_last_beat;
                ival = 1;
            end
            m_seen      = 1;
            m_last_beat = m_idx;
        end
        m_hist.push_back(v);
        if (m_hist.size() > HIST) void'(m_hist.pop_front());
        e.beat     = beat;
        e.strength = W'(m_strength);
        e.thr      = W'(thr);
        e.avg      = W'(avg);
        e.interval = IW'(m_interval);
        e.ival     = ival;
        e.full     = (m_hist.size() == HIST);
        exp_q.push_back(e);
    endtask

    // driver tasks: inputs change 1 time unit after the active edge
    task automatic send(input logic [W-1:0] v);
        bus.flux_valid = 1'b1;
        bus.flux_value = v;
        model_sample(longint'(v));
        @(posedge clk);
        #1;
    endtask

    task automatic stop_valid();
        bus.flux_valid = 1'b0;
    endtask

    task automatic send_one(input logic [W-1:0] v);
        send(v);
        stop_valid();
    endtask

    task automatic idle(input int n);
        stop_valid();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset          = 1'b1;
        bus.flux_valid = 1'b1;
        bus.flux_value = 500;
        repeat (n) @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.flux_valid = 1'b0;
        model_reset();
        if (exp_q.size() != 0) begin
            chk("exp_q_drained_before_reset", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic chk_all_zero();
        chk("rst_beat_pulse",     bus.beat_pulse, 0);
        chk("rst_beat_strength",  bus.beat_strength, 0);
        chk("rst_threshold",      bus.threshold, 0);
        chk("rst_flux_avg",       bus.flux_avg, 0);
        chk("rst_beat_interval",  bus.beat_interval, 0);
        chk("rst_interval_valid", bus.interval_valid, 0);
        chk("rst_hist_full",      bus.hist_full, 0);
    endtask

    // scoreboard monitor
    logic v_d = 1'b0;
    always @(posedge clk) v_d <= bus.flux_valid && !reset;

    always @(negedge clk) begin
        exp_t e;
        if (v_d) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_beat_pulse",     bus.beat_pulse, e.beat);
                chk("sb_beat_strength",  bus.beat_strength, e.strength);
                chk("sb_threshold",      bus.threshold, e.thr);
                chk("sb_flux_avg",       bus.flux_avg, e.avg);
                chk("sb_beat_interval",  bus.beat_interval, e.interval);
                chk("sb_interval_valid", bus.interval_valid, e.ival);
                chk("sb_hist_full",      bus.hist_full, e.full);
            end
        end else begin
            chk("idle_beat_pulse",     bus.beat_pulse, 0);
            chk("idle_interval_valid", bus.interval_valid, 0);
        end
    end

    initial begin
        logic [W-1:0] v;
        reset          = 1'b0;
        bus.flux_valid = 1'b0;
        bus.flux_value = '0;
        model_reset();

        // reset with valid held high
        do_reset(5);
        chk_all_zero();
        send_one(40);
        chk("first_avg_after_reset", bus.flux_avg, 0);

        // warm-up, strict threshold
        do_reset(2);
        for (int i = 0; i < 8; i++) send_one(100);
        chk("hist_full_after_8", bus.hist_full, 1);
        send_one(150);
        chk("avg_at_150", bus.flux_avg, 100);
        chk("thr_at_150", bus.threshold, 150);
        chk("no_beat_at_150", bus.beat_pulse, 0);

        // fresh run, first beat, refractory, interval
        do_reset(2);
        for (int i = 0; i < 8; i++) send_one(100);
        send_one(151);
        chk("beat_at_151", bus.beat_pulse, 1);
        chk("strength_at_151", bus.beat_strength, 1);
        chk("ival_first_beat", bus.interval_valid, 0);
        for (int i = 0; i < 4; i++) begin
            send_one(1000);
            chk("refractory_suppressed", bus.beat_pulse, 0);
        end
        send_one(1000);
        chk("avg_at_14", bus.flux_avg, 556);
        chk("thr_at_14", bus.threshold, 834);
        chk("beat_at_14", bus.beat_pulse, 1);
        chk("strength_at_14", bus.beat_strength, 166);
        chk("interval_at_14", bus.beat_interval, 5);
        chk("ival_at_14", bus.interval_valid, 1);

        // reset during refractory
        idle(1);
        do_reset(3);
        chk_all_zero();
        for (int i = 0; i < 8; i++) send_one(100);
        send_one(151);
        chk("beat_after_midreset", bus.beat_pulse, 1);
        chk("ival_after_midreset", bus.interval_valid, 0);

        // MIN_FLUX floor
        do_reset(2);
        for (int i = 0; i < 8; i++) send_one(0);
        send_one(10);
        chk("thr_zero_floor", bus.threshold, 0);
        chk("no_beat_below_min", bus.beat_pulse, 0);
        send_one(20);
        chk("avg_min_next", bus.flux_avg, 1);
        chk("thr_min_next", bus.threshold, 1);
        chk("beat_min_next", bus.beat_pulse, 1);

        // back-to-back samples
        do_reset(2);
        for (int i = 0; i < 8; i++) send(100);
        send(400);
        stop_valid();
        chk("b2b_beat", bus.beat_pulse, 1);
        idle(1);
        chk("b2b_beat_one_cycle", bus.beat_pulse, 0);

        // threshold saturation
        do_reset(2);
        for (int i = 0; i < 8; i++) send(32'hFFFF_FFF0);
        send_one(32'hFFFF_FFFF);
        chk("thr_saturated", bus.threshold, 32'hFFFF_FFFF);
        chk("no_beat_at_saturation", bus.beat_pulse, 0);

        // random stimulus
        do_reset(2);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 2000);
            else v = $urandom_range(50, 200);
            send(v);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(3);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/beat_detector.md
Name: beat_detector

Overview:
Downstream consumer of spectral_flux. Takes one flux sample per FFT frame and keeps a circular history of the last 2^HIST_LOG2 samples with a running sum. It declares a beat when the new flux exceeds an adaptive threshold, a scaled moving average of past flux. It also applies a refractory hold-off and reports the frame interval between beats for the tempo logic.

Parameters:
MAX_FLUX_LENGTH, 32, width of flux input and threshold/average outputs
HIST_LOG2, 3, log2 of history depth (HIST = 8 frames)
K_NUM, 3, threshold multiplier numerator
K_SHIFT, 1, threshold divider shift (default threshold = 1.5 x average)
REFRACTORY, 4, flux samples suppressed after each beat
MIN_FLUX, 16, absolute floor; flux below this never beats
INT_W, 16, width of beat interval counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
flux_valid  in  1  one-cycle strobe, flux_value is a new frame sample
flux_value  in  MAX_FLUX_LENGTH  spectral flux of the current frame
beat_pulse  out  1  one-cycle beat strobe
beat_strength  out  MAX_FLUX_LENGTH  flux_value minus threshold at the beat; held until next beat
threshold  out  MAX_FLUX_LENGTH  threshold used for the most recent sample
flux_avg  out  MAX_FLUX_LENGTH  history average used for the most recent sample
beat_interval  out  INT_W  samples between the last two beats
interval_valid  out  1  one-cycle strobe with beat_pulse when beat_interval was updated
hist_full  out  1  history holds HIST samples (warm-up complete)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset clears the history RAM, running sum, write pointer and fill count. It also clears the refractory and interval counters and the "seen first beat" flag. All outputs go to 0. flux_valid is ignored while reset=1. Reset mid-stream restarts warm-up.
- flux_valid may be high on consecutive cycles. Each high cycle is one sample, so throughput is one sample per clock.
- On a sample, decision uses only the history before the sample is written:
  - avg = sum >> HIST_LOG2 (floor).
  - thr = (avg*K_NUM) >> K_SHIFT. The intermediate product is wide enough not to overflow. The result saturates to all-ones at MAX_FLUX_LENGTH bits.
  - beat = hist_full && flux_value > thr (strict) && flux_value >= MIN_FLUX && refr_cnt == 0.
- History update on the same sample:
  - sum <= sum - hist[wr_ptr] + flux_value. sum is MAX_FLUX_LENGTH+HIST_LOG2 bits and never overflows.
  - hist[wr_ptr] <= flux_value; wr_ptr wraps from HIST-1 to 0.
  - fill count saturates at HIST; hist_full = (fill == HIST).
  - Unwritten entries read as 0.
- Latency: beat_pulse, threshold, flux_avg, beat_strength and interval_valid are registered 1 cycle after the flux_valid cycle. beat_pulse and interval_valid are high for exactly one cycle per beat.
- Refractory:
  - On a beat, refr_cnt loads REFRACTORY.
  - On each later sample with refr_cnt > 0, the sample is suppressed and refr_cnt decrements.
  - The history still updates during suppression.
- Interval:
  - int_cnt increments (saturating at 2^INT_W-1) on every sample after the first beat. It counts the beat sample as 1.
  - On a beat with the first-beat flag set: beat_interval <= int_cnt value including the current sample, interval_valid pulses, int_cnt resets.
  - The first beat after reset sets the flag only. interval_valid stays 0 and beat_interval stays 0.
- Warm-up: no beats while fill < HIST, including the sample that makes fill reach HIST. threshold and flux_avg still update.
- No flux_valid means no state change; outputs hold apart from the strobes, which return to 0.

Test Plan:
- Reset: hold reset 5 cycles with flux_valid=1, flux_value=500 -> all outputs 0, hist_full=0; the first sample after reset sees avg=0.
- Warm-up and threshold: samples 1-8 = 100 -> no beat, hist_full=1 after sample 8. Sample 9 = 150 -> flux_avg=100, threshold=150, no beat (strict). Fresh run, sample 9 = 151 -> beat_pulse 1 cycle later, beat_strength=1, interval_valid=0.
- Refractory and interval: continue after the 151 beat with samples 10-13 = 1000 -> no beat. Sample 14 = 1000 -> flux_avg=556, threshold=834, beat_pulse=1, beat_strength=166, beat_interval=5, interval_valid=1.
- MIN_FLUX floor: after reset, 8 samples of 0, then 10 -> threshold 0, no beat. Next 20 -> avg=1, threshold=1, beat.
- Back-to-back: 8 samples of 100 on consecutive cycles, then 400 on the next cycle -> beat_pulse exactly one cycle after the 400 cycle.
- Reset mid-operation: assert reset during refractory after a beat, then 8 samples of 100 and 151 -> beat fires (refractory cleared), interval_valid=0 (first-beat flag cleared).
